// File: rtl/sdds_reg_pipe.sv
// Dual-rail return-to-zero register pipeline with per-stage four-phase handshake and
// registered word completion; optional reset token seeding and constant-source mode.
module sdds_reg_pipe #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 3,
    parameter int unsigned      INIT_STAGE = DEPTH,
    parameter logic [WIDTH-1:0] INIT_VAL   = '0,
    parameter bit               SRC_CONST  = 1'b0,
    parameter logic [WIDTH-1:0] CONST_VAL  = '0
) (
    input  logic             ck,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_t,
    input  logic [WIDTH-1:0] d_f,
    output logic             d_ack,
    output logic [WIDTH-1:0] q_t,
    output logic [WIDTH-1:0] q_f,
    input  logic             q_ack,
    output logic             err
);

    typedef logic [DEPTH-1:0][WIDTH-1:0] word_arr_t;

    function automatic word_arr_t seed(input logic [WIDTH-1:0] v);
        word_arr_t r;
        r = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i == INIT_STAGE) r[i] = v;
        end
        return r;
    endfunction

    localparam word_arr_t        RST_T = seed(INIT_VAL);
    localparam word_arr_t        RST_F = seed(~INIT_VAL);
    localparam logic [DEPTH-1:0] RST_C = (INIT_STAGE < DEPTH) ? (DEPTH'(1) << INIT_STAGE) : '0;

    word_arr_t        st_t, st_f;
    word_arr_t        in_t, in_f;
    word_arr_t        nx_t, nx_f;
    logic [DEPTH-1:0] c, c_nx, go;
    logic [WIDTH-1:0] src_t, src_f;

    // A stage may take new DATA only while its successor is not yet complete.
    assign go = {~q_ack, ~c[DEPTH-1:1]};

    // Stage 0 source: external rails, or a constant token issued only when stage 0 may fill.
    always_comb begin
        src_t = d_t;
        src_f = d_f;
        if (SRC_CONST) begin
            src_t = go[0] ? CONST_VAL  : '0;
            src_f = go[0] ? ~CONST_VAL : '0;
        end
    end

    assign in_t = {st_t[DEPTH-2:0], src_t};
    assign in_f = {st_f[DEPTH-2:0], src_f};

    // Hysteresis rails and word completion: rise only on go, fall only on ~go with input NULL.
    always_comb begin
        nx_t = st_t;
        nx_f = st_f;
        c_nx = c;
        for (int i = 0; i < DEPTH; i++) begin
            nx_t[i] = (in_t[i] & {WIDTH{go[i]}}) | (st_t[i] & (in_t[i] | {WIDTH{go[i]}}));
            nx_f[i] = (in_f[i] & {WIDTH{go[i]}}) | (st_f[i] & (in_f[i] | {WIDTH{go[i]}}));
            if (&(st_t[i] ^ st_f[i]))
                c_nx[i] = 1'b1;
            else if (~|(st_t[i] | st_f[i]))
                c_nx[i] = 1'b0;
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            st_t <= RST_T;
            st_f <= RST_F;
            c    <= RST_C;
            err  <= 1'b0;
        end else begin
            st_t <= nx_t;
            st_f <= nx_f;
            c    <= c_nx;
            err  <= err | (|(nx_t & nx_f));
        end
    end

    assign d_ack = c[0];
    assign q_t   = st_t[DEPTH-1];
    assign q_f   = st_f[DEPTH-1];

endmodule

// File: tb/tb_sdds_reg_pipe.sv
// Directed bench for sdds_reg_pipe: reset seeding, latency, backpressure, partial words,
// constant source, illegal-rail flag and asynchronous reset.
module tb_sdds_reg_pipe;

    logic       ck;
    logic       reset;
    logic [7:0] d_t, d_f, q_t, q_f;
    logic       d_ack, q_ack, err;
    logic [7:0] cd_t, cd_f, cq_t, cq_f;
    logic       cd_ack, cq_ack, c_err;

    int n_chk  = 0;
    int n_pass = 0;

    sdds_reg_pipe #(
        .WIDTH(8), .DEPTH(3), .INIT_STAGE(1), .INIT_VAL(8'hA5),
        .SRC_CONST(1'b0), .CONST_VAL(8'h00)
    ) u_dut (
        .ck(ck), .reset(reset), .d_t(d_t), .d_f(d_f), .d_ack(d_ack),
        .q_t(q_t), .q_f(q_f), .q_ack(q_ack), .err(err)
    );

    sdds_reg_pipe #(
        .WIDTH(8), .DEPTH(3), .INIT_STAGE(3), .INIT_VAL(8'h00),
        .SRC_CONST(1'b1), .CONST_VAL(8'h0F)
    ) u_cst (
        .ck(ck), .reset(reset), .d_t(cd_t), .d_f(cd_f), .d_ack(cd_ack),
        .q_t(cq_t), .q_f(cq_f), .q_ack(cq_ack), .err(c_err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    logic [7:0]  tok [4];
    logic [15:0] rcv [$];
    int          sent;

    // Four-phase producer: DATA when stage 0 is empty, NULL once it reports complete.
    task automatic prod_step();
        if (d_t == 8'h00 && d_f == 8'h00 && !d_ack && sent < 4) begin
            d_t = tok[sent];
            d_f = ~tok[sent];
            sent++;
        end else if ((d_t | d_f) != 8'h00 && d_ack) begin
            d_t = 8'h00;
            d_f = 8'h00;
        end
    endtask

    task automatic cons_step();
        if ((q_t | q_f) != 8'h00 && !q_ack) begin
            rcv.push_back({q_t, q_f});
            q_ack = 1'b1;
        end else if (q_t == 8'h00 && q_f == 8'h00 && q_ack) begin
            q_ack = 1'b0;
        end
    endtask

    initial begin
        int n_cd;
        int n_cn;
        reset  = 1'b0;
        d_t    = 8'h00;
        d_f    = 8'h00;
        q_ack  = 1'b0;
        cd_t   = 8'h00;
        cd_f   = 8'h00;
        cq_ack = 1'b0;
        tok[0] = 8'h11; tok[1] = 8'h22; tok[2] = 8'h33; tok[3] = 8'h44;
        sent   = 0;
        n_cd   = 0;
        n_cn   = 0;

        // Reset seeding: token A5 sits in stage 1, reaches q on the first edge.
        @(posedge ck);
        #1 reset = 1'b1;
        chk("rst_q_t", q_t, 8'h00);
        chk("rst_q_f", q_f, 8'h00);
        chk("rst_d_ack", d_ack, 1'b0);
        chk("rst_err", err, 1'b0);
        tick(1);
        chk("seed_q_t", q_t, 8'hA5);
        chk("seed_q_f", q_f, 8'h5A);
        tick(3);
        chk("seed_hold", {q_t, q_f}, 16'hA55A);
        q_ack = 1'b1;
        tick(1);
        chk("seed_drain", {q_t, q_f}, 16'h0000);
        q_ack = 1'b0;
        tick(2);
        chk("empty_d_ack", d_ack, 1'b0);

        // Latency: DATA at q after 3 edges, d_ack after 2; NULL likewise.
        d_t = 8'h3C; d_f = 8'hC3;
        tick(1);
        chk("lat1_q", {q_t, q_f}, 16'h0000);
        chk("lat1_ack", d_ack, 1'b0);
        tick(1);
        chk("lat2_ack", d_ack, 1'b1);
        chk("lat2_q", {q_t, q_f}, 16'h0000);
        tick(1);
        chk("lat3_q", {q_t, q_f}, 16'h3CC3);
        d_t = 8'h00; d_f = 8'h00; q_ack = 1'b1;
        tick(2);
        chk("null2_ack", d_ack, 1'b0);
        chk("null2_q", {q_t, q_f}, 16'h3CC3);
        tick(1);
        chk("null3_q", {q_t, q_f}, 16'h0000);
        q_ack = 1'b0; d_t = 8'hC3; d_f = 8'h3C;
        tick(1);
        chk("c3_1_ack", d_ack, 1'b0);
        tick(1);
        chk("c3_2_ack", d_ack, 1'b1);
        tick(1);
        chk("c3_3_q", {q_t, q_f}, 16'hC33C);
        d_t = 8'h00; d_f = 8'h00; q_ack = 1'b1;
        tick(3);
        chk("c3_null_q", {q_t, q_f}, 16'h0000);
        q_ack = 1'b0;
        tick(2);

        // Backpressure: consumer idle, producer pushes; two tokens stack.
        for (int k = 0; k < 20; k++) begin
            prod_step();
            tick(1);
        end
        chk("stall_d_ack", d_ack, 1'b1);
        chk("stall_q", {q_t, q_f}, 16'h11EE);
        chk("stall_sent", 32'(sent), 32'd2);
        for (int k = 0; k < 200; k++) begin
            prod_step();
            cons_step();
            tick(1);
        end
        chk("bp_count", 32'(rcv.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rcv.size()) chk($sformatf("bp_tok%0d", i), rcv[i], {tok[i], ~tok[i]});
        end
        chk("bp_empty_q", {q_t, q_f}, 16'h0000);
        chk("bp_empty_ack", d_ack, 1'b0);

        // Partial word: bit 7 NULL keeps completion low; partial bits still flow.
        d_t = 8'h55; d_f = 8'h2A;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk($sformatf("part_ack%0d", k), d_ack, 1'b0);
        end
        chk("part_q", {q_t, q_f}, 16'h552A);
        d_t = 8'hD5;
        tick(1);
        chk("full1_ack", d_ack, 1'b0);
        tick(1);
        chk("full2_ack", d_ack, 1'b1);
        tick(1);
        chk("full3_q", {q_t, q_f}, 16'hD52A);
        d_t = 8'h00; d_f = 8'h00; q_ack = 1'b1;
        tick(3);
        chk("full_drain_q", {q_t, q_f}, 16'h0000);
        chk("full_drain_ack", d_ack, 1'b0);
        q_ack = 1'b0;
        tick(3);

        // Constant source: consumer handshake sees 0F / NULL alternately.
        for (int k = 0; k < 80; k++) begin
            if ((cq_t | cq_f) != 8'h00 && !cq_ack) begin
                chk("const_data", {cq_t, cq_f}, 16'h0FF0);
                n_cd++;
                cq_ack = 1'b1;
            end else if (cq_t == 8'h00 && cq_f == 8'h00 && cq_ack) begin
                n_cn++;
                cq_ack = 1'b0;
            end
            tick(1);
        end
        chk("const_ndata", 32'(n_cd >= 3), 32'd1);
        chk("const_nnull", 32'(n_cn >= 3), 32'd1);

        // Illegal rails: err on the edge bit 2 becomes 11, data not masked.
        chk("pre_err", err, 1'b0);
        d_t = 8'h3C; d_f = 8'hC7;
        tick(1);
        chk("err_set", err, 1'b1);
        tick(2);
        chk("err_hold", err, 1'b1);
        chk("err_q", {q_t, q_f}, 16'h3CC7);
        chk("err_d_ack", d_ack, 1'b0);

        // Asynchronous reset between edges.
        #3 reset = 1'b0;
        #1;
        chk("arst_q", {q_t, q_f}, 16'h0000);
        chk("arst_err", err, 1'b0);
        chk("arst_d_ack", d_ack, 1'b0);
        chk("arst_cq", {cq_t, cq_f}, 16'h0000);
        tick(2);
        chk("arst_err_held", err, 1'b0);
        chk("arst_q_held", {q_t, q_f}, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
